// File: rtl/enable_pixel_source_pkg.sv
// Shared types and width helpers for the enable-stepped raster test-pattern source.
package enable_pixel_source_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} pixStateT;

  localparam int H_ACTIVE_DEF = 16;
  localparam int V_ACTIVE_DEF = 8;
  localparam int H_BLANK_DEF  = 2;
  localparam int V_BLANK_DEF  = 1;
  localparam int DATA_W_DEF   = 8;

  function automatic int cntWidth(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Blank down-counter holds at most max(H_BLANK,V_BLANK)-1; kept at least 1 bit wide.
  function automatic int blankWidth(input int hb, input int vb);
    int m;
    m = (hb > vb) ? hb : vb;
    return (m >= 1) ? ((m + 1 > 2) ? $clog2(m + 1) : 1) : 1;
  endfunction

  localparam int HW_DEF = cntWidth(H_ACTIVE_DEF);
  localparam int VW_DEF = cntWidth(V_ACTIVE_DEF);

endpackage

// File: rtl/raster_counter.sv
// Column/row position counters; h wraps on its own, v steps only when told to.
module raster_counter #(
  parameter int H_ACTIVE = 16,
  parameter int V_ACTIVE = 8,
  parameter int HW       = 4,
  parameter int VW       = 3
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iClear,
  input  logic          iStepH,
  input  logic          iStepV,
  output logic [HW-1:0] hCnt,
  output logic [VW-1:0] vCnt,
  output logic          hLast,
  output logic          vLast
);

  assign hLast = (hCnt == HW'(H_ACTIVE - 1));
  assign vLast = (vCnt == VW'(V_ACTIVE - 1));

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      hCnt <= '0;
      vCnt <= '0;
    end else if (iClear) begin
      hCnt <= '0;
      vCnt <= '0;
    end else begin
      if (iStepH) hCnt <= hLast ? '0 : hCnt + HW'(1);
      if (iStepV) vCnt <= vLast ? '0 : vCnt + VW'(1);
    end
  end

endmodule

// File: rtl/enable_pixel_source.sv
// Raster test-pattern source stepped by a clock-enable strobe on the fast clock.
//   state  | meaning
//   IDLE   | waiting for iStart
//   ACTIVE | each enable emits one pixel
//   HBLANK | silent enables after a line
//   VBLANK | silent enables after the last line's HBLANK
module enable_pixel_source
  import enable_pixel_source_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int H_BLANK  = H_BLANK_DEF,
  parameter int V_BLANK  = V_BLANK_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iEnable,
  input  logic                          iStart,
  input  logic                          iContinuous,
  output logic                          oValid,
  output logic [DATA_W-1:0]             oData,
  output logic [cntWidth(H_ACTIVE)-1:0] oHCnt,
  output logic [cntWidth(V_ACTIVE)-1:0] oVCnt,
  output logic                          oFrameStart,
  output logic                          oLineEnd,
  output logic                          oFrameEnd,
  output logic                          oBusy
);

  localparam int HW = cntWidth(H_ACTIVE);
  localparam int VW = cntWidth(V_ACTIVE);
  localparam int BW = blankWidth(H_BLANK, V_BLANK);

  pixStateT          state, stateNext;
  logic [BW-1:0]     blankCnt, blankNext;
  logic [DATA_W-1:0] dataCnt;
  logic [HW-1:0]     hCnt;
  logic [VW-1:0]     vCnt;
  logic              hLast, vLast;
  logic              clearCnt, stepH, stepV, emit, frameDone;

  raster_counter #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .HW      (HW),
    .VW      (VW)
  ) uRaster (
    .iClk  (iClk),
    .iRst  (iRst),
    .iClear(clearCnt),
    .iStepH(stepH),
    .iStepV(stepV),
    .hCnt  (hCnt),
    .vCnt  (vCnt),
    .hLast (hLast),
    .vLast (vLast)
  );

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state    <= IDLE;
      blankCnt <= '0;
      dataCnt  <= '0;
    end else begin
      state    <= stateNext;
      blankCnt <= blankNext;
      if (clearCnt)  dataCnt <= '0;
      else if (emit) dataCnt <= dataCnt + DATA_W'(1);
    end
  end

  always_comb begin
    stateNext = state;
    blankNext = blankCnt;
    clearCnt  = 1'b0;
    stepH     = 1'b0;
    stepV     = 1'b0;
    emit      = 1'b0;
    frameDone = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          stateNext = ACTIVE;
          clearCnt  = 1'b1;
        end
      end
      ACTIVE: begin
        if (iEnable) begin
          emit  = 1'b1;
          stepH = 1'b1;
          if (hLast) begin
            if (H_BLANK > 0) begin
              stateNext = HBLANK;
              blankNext = BW'(H_BLANK - 1);
            end else if (!vLast) begin
              stepV = 1'b1;
            end else if (V_BLANK > 0) begin
              stateNext = VBLANK;
              blankNext = BW'(V_BLANK - 1);
            end else begin
              frameDone = 1'b1;
            end
          end
        end
      end
      HBLANK: begin
        if (iEnable) begin
          if (blankCnt == '0) begin
            if (!vLast) begin
              stepV     = 1'b1;
              stateNext = ACTIVE;
            end else if (V_BLANK > 0) begin
              stateNext = VBLANK;
              blankNext = BW'(V_BLANK - 1);
            end else begin
              frameDone = 1'b1;
            end
          end else begin
            blankNext = blankCnt - BW'(1);
          end
        end
      end
      VBLANK: begin
        if (iEnable) begin
          if (blankCnt == '0) frameDone = 1'b1;
          else                blankNext = blankCnt - BW'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
    // Counter clear outranks the h step taken by a blank-free last pixel.
    if (frameDone) begin
      if (iContinuous) begin
        stateNext = ACTIVE;
        clearCnt  = 1'b1;
      end else begin
        stateNext = IDLE;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      oValid      <= 1'b0;
      oData       <= '0;
      oHCnt       <= '0;
      oVCnt       <= '0;
      oFrameStart <= 1'b0;
      oLineEnd    <= 1'b0;
      oFrameEnd   <= 1'b0;
      oBusy       <= 1'b0;
    end else begin
      oValid      <= emit;
      oFrameStart <= emit && (hCnt == '0) && (vCnt == '0);
      oLineEnd    <= emit && hLast;
      oFrameEnd   <= emit && hLast && vLast;
      oBusy       <= (stateNext != IDLE);
      if (emit) begin
        oData <= dataCnt;
        oHCnt <= hCnt;
        oVCnt <= vCnt;
      end
    end
  end

endmodule

// File: tb/tb_enable_pixel_source.sv
// Directed bench: blanked instance (4x2, HB=1, VB=2) and blank-free instance (4x3, 3-bit data).
module tb_enable_pixel_source;

  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  int nChecks = 0;
  int nFails  = 0;

  // Instance A: H_ACTIVE=4, V_ACTIVE=2, H_BLANK=1, V_BLANK=2, DATA_W=8
  logic       aRst = 1'b0, aEnable = 1'b0, aStart = 1'b0, aCont = 1'b0;
  logic       aValid, aFs, aLe, aFe, aBusy;
  logic [7:0] aData;
  logic [1:0] aHCnt;
  logic [0:0] aVCnt;

  enable_pixel_source #(
    .H_ACTIVE(4), .V_ACTIVE(2), .H_BLANK(1), .V_BLANK(2), .DATA_W(8)
  ) uDutA (
    .iClk(iClk), .iRst(aRst), .iEnable(aEnable), .iStart(aStart), .iContinuous(aCont),
    .oValid(aValid), .oData(aData), .oHCnt(aHCnt), .oVCnt(aVCnt),
    .oFrameStart(aFs), .oLineEnd(aLe), .oFrameEnd(aFe), .oBusy(aBusy)
  );

  // Instance B: H_ACTIVE=4, V_ACTIVE=3, no blanking, DATA_W=3
  logic       bRst = 1'b0, bEnable = 1'b0, bStart = 1'b0, bCont = 1'b0;
  logic       bValid, bFs, bLe, bFe, bBusy;
  logic [2:0] bData;
  logic [1:0] bHCnt;
  logic [1:0] bVCnt;

  enable_pixel_source #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(0), .V_BLANK(0), .DATA_W(3)
  ) uDutB (
    .iClk(iClk), .iRst(bRst), .iEnable(bEnable), .iStart(bStart), .iContinuous(bCont),
    .oValid(bValid), .oData(bData), .oHCnt(bHCnt), .oVCnt(bVCnt),
    .oFrameStart(bFs), .oLineEnd(bLe), .oFrameEnd(bFe), .oBusy(bBusy)
  );

  int quietErr = 0;
  int validCnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clkA(input logic en, input logic st);
    aEnable = en;
    aStart  = st;
    @(posedge iClk);
    #1;
    aEnable = 1'b0;
    aStart  = 1'b0;
  endtask

  // Frame-step index (12 enables per frame) -> pixel index, or -1 for a blank tick.
  function automatic int pixOfA(input int s);
    if (s < 4) return s;
    if (s >= 5 && s <= 8) return s - 1;
    return -1;
  endfunction

  function automatic logic [13:0] expPixA(input int k);
    return {8'(k), 2'(k % 4), 1'(k / 4), (k == 0), (k % 4 == 3), (k == 7)};
  endfunction

  // One enable clock then seven quiet clocks; the quiet clocks must hold data and keep strobes low.
  task automatic enStepA(output logic vld, output logic [13:0] pix);
    logic [10:0] held;
    clkA(1'b1, 1'b0);
    vld  = aValid;
    pix  = {aData, aHCnt, aVCnt, aFs, aLe, aFe};
    held = {aData, aHCnt, aVCnt};
    repeat (7) begin
      clkA(1'b0, 1'b0);
      if (aValid || aFs || aLe || aFe || ({aData, aHCnt, aVCnt} != held)) quietErr++;
    end
  endtask

  task automatic runA(input int first, input int n, input int dropAt);
    logic        vld;
    logic [13:0] pix;
    int          p;
    for (int s = first; s < first + n; s++) begin
      if (s == dropAt) aCont = 1'b0;
      enStepA(vld, pix);
      if (vld) validCnt++;
      p = pixOfA(s % 12);
      if (p >= 0) check("pixel", {17'd0, vld, pix}, {17'd0, 1'b1, expPixA(p)});
      else        check("blank", {31'd0, vld}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(posedge iClk);
    #1;
    check("resetA", {aValid, aData, aHCnt, aVCnt, aFs, aLe, aFe, aBusy}, 0);
    check("resetB", {bValid, bData, bHCnt, bVCnt, bFs, bLe, bFe, bBusy}, 0);
    aRst = 1'b1;
    bRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1;

    // Single frame, iContinuous low
    aCont    = 1'b0;
    quietErr = 0;
    validCnt = 0;
    clkA(1'b0, 1'b1);
    check("startBusy", {aBusy, aValid}, 2'b10);
    runA(0, 12, -1);
    check("frameValidCount", validCnt, 8);
    check("frameEndIdle", aBusy, 1'b0);
    check("quietSpacing", quietErr, 0);
    runA(0, 0, -1);
    clkA(1'b1, 1'b0);
    check("idleNoPixel", {aValid, aBusy}, 2'b00);

    // Three continuous frames, dropping iContinuous before the last decision enable
    aCont    = 1'b1;
    quietErr = 0;
    validCnt = 0;
    clkA(1'b0, 1'b1);
    runA(0, 36, 35);
    check("contValidCount", validCnt, 24);
    check("contEndIdle", aBusy, 1'b0);
    check("contQuiet", quietErr, 0);

    // Start coincident with enable, then reset after the fifth pixel
    aCont = 1'b0;
    clkA(1'b1, 1'b1);
    check("coincidentNoPixel", {aValid, aBusy}, 2'b01);
    runA(0, 6, -1);
    check("preResetData", {aData, aBusy}, {8'd4, 1'b1});
    #2;
    aRst = 1'b0;
    #1;
    check("asyncReset", {aValid, aData, aHCnt, aVCnt, aFs, aLe, aFe, aBusy}, 0);
    repeat (2) clkA(1'b0, 1'b0);
    aRst     = 1'b1;
    validCnt = 0;
    for (int i = 0; i < 12; i++) begin
      clkA(1'b1, 1'b0);
      if (aValid) validCnt++;
    end
    check("postResetSilent", {validCnt[30:0], aBusy}, 0);

    // Blank-free instance: enable every clock over three continuous frames
    bCont  = 1'b1;
    bStart = 1'b1;
    @(posedge iClk);
    #1;
    bStart  = 1'b0;
    bEnable = 1'b1;
    for (int s = 0; s < 36; s++) begin
      int k;
      k = s % 12;
      if (s == 35) bCont = 1'b0;
      @(posedge iClk);
      #1;
      check("b2bPixel", {bValid, bData, bHCnt, bVCnt, bFs, bLe, bFe},
            {1'b1, 3'(k), 2'(k % 4), 2'(k / 4), (k == 0), (k % 4 == 3), (k == 11)});
    end
    check("b2bEndIdle", bBusy, 1'b0);
    @(posedge iClk);
    #1;
    bEnable = 1'b0;
    check("b2bIdleNoPixel", bValid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/enable_pixel_source.md
Name: enable_pixel_source

Overview:
- Consumer-side counterpart of the codebase's clock-enable strobe generator.
- Advances a raster pixel stream by exactly one step on each clock where iEnable is high, and emits a counting test pattern with position and framing markers.
- Drives the line-buffer path and its testbenches at the enable-decimated pixel rate.
- All logic runs on the single fast clock; there is no derived clock.

Parameters:
- H_ACTIVE, 16: active pixels per line (>=2).
- V_ACTIVE, 8: active lines per frame (>=2).
- H_BLANK, 2: enable ticks of horizontal blank after each line (0 allowed = no blank).
- V_BLANK, 1: enable ticks of vertical blank after the last line's HBLANK (0 allowed).
- DATA_W, 8: pixel data width.

Ports:
- iClk  in  1  clock.
- iRst  in  1  reset. Asynchronous, active-low.
- iEnable  in  1  step strobe, one-clock pulses (e.g. 1 in 8 clocks).
- iStart  in  1  begin a frame; honoured only in IDLE.
- iContinuous  in  1  sampled at frame end: 1 = start next frame, 0 = return to IDLE.
- oValid  out  1  one-clock pulse; oData/oHCnt/oVCnt are valid.
- oData  out  DATA_W  pixel value.
- oHCnt  out  clog2(H_ACTIVE)  column of current pixel.
- oVCnt  out  clog2(V_ACTIVE)  row of current pixel.
- oFrameStart  out  1  pulses with pixel (0,0).
- oLineEnd  out  1  pulses with the last pixel of every line.
- oFrameEnd  out  1  pulses with the last pixel of the frame.
- oBusy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (iRst low, asynchronous):
  - State = IDLE; all counters = 0.
  - All outputs = 0.
  - Reset mid-frame aborts the frame immediately. No pulses are emitted on release.
- All outputs are registered.
- Pixel timing: when iEnable=1 in ACTIVE, the pixel appears on the next clock.
  - oValid=1 for exactly that one clock, together with its oData/oHCnt/oVCnt and any markers.
  - Between pulses, oValid and the markers are 0. oData/oHCnt/oVCnt hold their last values.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK. Transitions, counters and blank counts change only on clocks with iEnable=1, except IDLE->ACTIVE.
- IDLE -> ACTIVE: on any clock with iStart=1, whether or not iEnable is high that cycle.
  - If iStart and iEnable are high in the same clock, that enable does not emit a pixel.
  - The first pixel comes on the first iEnable after the start clock.
- ACTIVE:
  - Each enable emits pixel (h,v), then h increments.
  - At h==H_ACTIVE-1: assert oLineEnd and wrap h to 0.
    - If H_BLANK>0, go to HBLANK.
    - If H_BLANK==0 and not the last line, stay in ACTIVE with v+1.
    - If H_BLANK==0 and on the last line, take the end-of-line exit below.
- HBLANK: count H_BLANK enables, then exit:
  - v < V_ACTIVE-1: v+1, go to ACTIVE.
  - otherwise: go to VBLANK, or to the frame-end decision if V_BLANK==0.
- VBLANK: count V_BLANK enables, then make the frame-end decision.
- Frame-end decision: uses iContinuous sampled on the deciding enable clock.
  - 1: v=0, data=0, go to ACTIVE. The next enable emits pixel (0,0).
  - 0: go to IDLE.
- Markers:
  - oFrameStart with (0,0).
  - oFrameEnd with (H_ACTIVE-1, V_ACTIVE-1); oLineEnd is also high on that pixel.
- oData = running pixel index within the frame, modulo 2^DATA_W. It resets to 0 at each frame start.
- iStart outside IDLE is ignored.
- iEnable high on consecutive clocks is legal: one step per clock.
- oBusy drops on the clock after the IDLE transition.

Decomposition:
- Package enable_pixel_source_pkg holds:
  - the state enum (IDLE, ACTIVE, HBLANK, VBLANK);
  - localparam widths HW/VW derived via clog2;
  - a blank-counter width of clog2(max(H_BLANK,V_BLANK)+1).
- One sub-module, raster_counter: h/v counters with enable, wrap flags and last-line flag. The FSM and output registers stay in the top level.

Test Plan (H_ACTIVE=4, V_ACTIVE=2, H_BLANK=1, V_BLANK=2, DATA_W=8, iEnable every 8th clock):
- Basic frame: pulse iStart with iContinuous=0.
  - Exactly 8 oValid pulses, oData 0..7, (h,v) = (0,0)..(3,1).
  - oFrameStart on the 1st pulse, oLineEnd on the 4th and 8th, oFrameEnd on the 8th.
  - Then 1 HBLANK tick and 2 VBLANK ticks; oBusy low after them.
- Enable spacing: each oValid is exactly 1 clock after its iEnable clock; oValid count == enable count minus blank ticks.
- Continuous: iContinuous=1 over 3 frames.
  - Gap of 3 silent enables (1 H + 2 V) between frames.
  - oData restarts at 0 each frame.
- Start coincident with enable: iStart and iEnable in the same clock → no pixel on that enable; the first pixel follows the next enable.
- Reset mid-frame: iRst low after the 5th pixel → all outputs 0 asynchronously. After release, no oValid until a new iStart.
- Blank-free variant (H_BLANK=0, V_BLANK=0, iEnable every clock, continuous): back-to-back oValid every clock with no gaps; oData wraps correctly across frames.
